// File: rtl/pong_core_param_if.sv
// Board-side signal bundle for the pong core: raw buttons in, LED bar and score outputs out.
interface pong_core_param_if #(
    parameter int unsigned N_LEDS  = 8,
    parameter int unsigned SCORE_W = 4
);
    logic               p1_btn;
    logic               p2_btn;
    logic               start;
    logic [N_LEDS-1:0]  led;
    logic [SCORE_W-1:0] p1_score;
    logic [SCORE_W-1:0] p2_score;
    logic [1:0]         winner;

    modport master (
        output p1_btn, p2_btn, start,
        input  led, p1_score, p2_score, winner
    );

    modport slave (
        input  p1_btn, p2_btn, start,
        output led, p1_score, p2_score, winner
    );
endinterface

// File: rtl/pong_core_param.sv
// One-dimensional pong on an N-LED bar: debounced buttons, tick-enable ball stepping,
// per-return speed-up, serve alternation, scoring and a timed win flash.
module pong_core_param #(
    parameter int unsigned N_LEDS        = 8,
    parameter int unsigned WIN_SCORE     = 5,
    parameter int unsigned SCORE_W       = 4,
    parameter int unsigned TICK_DIV      = 10000000,
    parameter int unsigned MIN_DIV       = 2500000,
    parameter int unsigned SPEEDUP_SHIFT = 3,
    parameter int unsigned DB_CYCLES     = 16,
    parameter int unsigned FLASH_TOGGLES = 10
) (
    input  logic            clk,
    input  logic            rst,
    pong_core_param_if.slave io_bus
);
    localparam int unsigned POS_W = $clog2(N_LEDS);
    localparam int unsigned PER_W = $clog2(TICK_DIV + 1);
    localparam int unsigned DB_W  = $clog2(DB_CYCLES + 1);
    localparam int unsigned FT_W  = $clog2(FLASH_TOGGLES + 1);
    localparam int unsigned N_IN  = 3;

    localparam logic [POS_W-1:0] P1_END   = POS_W'(N_LEDS - 1);
    localparam logic [POS_W-1:0] P2_END   = POS_W'(0);
    localparam logic [POS_W-1:0] P1_SERVE = POS_W'(N_LEDS - 2);
    localparam logic [POS_W-1:0] P2_SERVE = POS_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SERVE,
        ST_PLAY,
        ST_POINT,
        ST_FLASH
    } state_t;

    // ------------------------------------------------------------------
    // Input conditioning: bit 0 = p1, bit 1 = p2, bit 2 = start
    // ------------------------------------------------------------------
    logic [N_IN-1:0] w_raw;
    logic [N_IN-1:0] r_sync1;
    logic [N_IN-1:0] r_sync2;
    logic [N_IN-1:0] r_db;
    logic [N_IN-1:0] r_db_d;
    logic [N_IN-1:0] r_press;
    logic [DB_W-1:0] r_db_cnt [N_IN];

    logic w_p1_press;
    logic w_p2_press;
    logic w_start_press;

    assign w_raw = {io_bus.start, io_bus.p2_btn, io_bus.p1_btn};

    // Level is accepted only after DB_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_db    <= '0;
            r_db_d  <= '0;
            r_press <= '0;
            for (int i = 0; i < N_IN; i++) begin
                r_db_cnt[i] <= '0;
            end
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
            r_db_d  <= r_db;
            r_press <= r_db & ~r_db_d;
            for (int i = 0; i < N_IN; i++) begin
                if (r_sync2[i] == r_db[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] == DB_W'(DB_CYCLES - 1)) begin
                    r_db[i]     <= r_sync2[i];
                    r_db_cnt[i] <= '0;
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    assign w_p1_press    = r_press[0];
    assign w_p2_press    = r_press[1];
    assign w_start_press = r_press[2];

    // ------------------------------------------------------------------
    // Game state
    // ------------------------------------------------------------------
    state_t             r_state;
    logic [POS_W-1:0]   r_pos;
    logic               r_dir;
    logic               r_serve_p1;
    logic [PER_W-1:0]   r_period;
    logic [PER_W-1:0]   r_tick_cnt;
    logic [FT_W-1:0]    r_flash_cnt;
    logic [N_LEDS-1:0]  r_led;
    logic [SCORE_W-1:0] r_p1_score;
    logic [SCORE_W-1:0] r_p2_score;
    logic [1:0]         r_winner;

    logic [PER_W-1:0]   w_tick_lim;
    logic               w_tick;
    logic [PER_W-1:0]   w_per_dec;
    logic [PER_W-1:0]   w_per_next;
    logic               w_rx_press;
    logic               w_at_rx_end;
    logic               w_return;
    logic               w_point;
    logic               w_step;
    logic [POS_W-1:0]   w_pos_step;

    function automatic logic [N_LEDS-1:0] onehot(input logic [POS_W-1:0] p);
        onehot = N_LEDS'(1) << p;
    endfunction

    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
        sat_inc = (s == SCORE_W'(WIN_SCORE)) ? s : s + SCORE_W'(1);
    endfunction

    // The flash always runs at the base rate, independent of the rally speed.
    assign w_tick_lim = (r_state == ST_FLASH) ? PER_W'(TICK_DIV - 1) : r_period - PER_W'(1);
    assign w_tick     = (r_tick_cnt == w_tick_lim);

    assign w_per_dec  = r_period - (r_period >> SPEEDUP_SHIFT);
    assign w_per_next = (w_per_dec < PER_W'(MIN_DIV)) ? PER_W'(MIN_DIV) : w_per_dec;

    // Only the player the ball is heading toward is listened to.
    assign w_rx_press  = r_dir ? w_p1_press : w_p2_press;
    assign w_at_rx_end = r_dir ? (r_pos == P1_END) : (r_pos == P2_END);
    assign w_return    = w_rx_press && w_at_rx_end;
    assign w_point     = w_rx_press ? !w_at_rx_end : (w_tick && w_at_rx_end);
    assign w_step      = !w_rx_press && w_tick && !w_at_rx_end;
    assign w_pos_step  = r_dir ? r_pos + POS_W'(1) : r_pos - POS_W'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_pos       <= '0;
            r_dir       <= 1'b0;
            r_serve_p1  <= 1'b1;
            r_period    <= PER_W'(TICK_DIV);
            r_tick_cnt  <= '0;
            r_flash_cnt <= '0;
            r_led       <= '0;
            r_p1_score  <= '0;
            r_p2_score  <= '0;
            r_winner    <= 2'b00;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    r_led      <= '0;
                    r_tick_cnt <= '0;
                    if (w_start_press) begin
                        r_state <= ST_SERVE;
                    end
                end

                ST_SERVE: begin
                    if (r_serve_p1) begin
                        r_pos <= P1_SERVE;
                        r_dir <= 1'b0;
                        r_led <= onehot(P1_SERVE);
                    end else begin
                        r_pos <= P2_SERVE;
                        r_dir <= 1'b1;
                        r_led <= onehot(P2_SERVE);
                    end
                    r_period   <= PER_W'(TICK_DIV);
                    r_tick_cnt <= '0;
                    r_state    <= ST_PLAY;
                end

                ST_PLAY: begin
                    r_tick_cnt <= w_tick ? '0 : r_tick_cnt + PER_W'(1);
                    if (w_return) begin
                        r_dir      <= ~r_dir;
                        r_tick_cnt <= '0;
                        r_period   <= w_per_next;
                    end else if (w_point) begin
                        // Receiver failed: the player the ball came from scores.
                        if (r_dir) begin
                            r_p2_score <= sat_inc(r_p2_score);
                        end else begin
                            r_p1_score <= sat_inc(r_p1_score);
                        end
                        r_led      <= '0;
                        r_tick_cnt <= '0;
                        r_state    <= ST_POINT;
                    end else if (w_step) begin
                        r_pos <= w_pos_step;
                        r_led <= onehot(w_pos_step);
                    end
                end

                ST_POINT: begin
                    if ((r_p1_score == SCORE_W'(WIN_SCORE)) ||
                        (r_p2_score == SCORE_W'(WIN_SCORE))) begin
                        r_winner    <= (r_p1_score == SCORE_W'(WIN_SCORE)) ? 2'b01 : 2'b10;
                        r_led       <= '1;
                        r_tick_cnt  <= '0;
                        r_flash_cnt <= '0;
                        r_state     <= ST_FLASH;
                    end else begin
                        r_serve_p1 <= ~r_serve_p1;
                        r_state    <= ST_IDLE;
                    end
                end

                ST_FLASH: begin
                    r_tick_cnt <= w_tick ? '0 : r_tick_cnt + PER_W'(1);
                    if (w_tick) begin
                        // The last inversion stays visible for a full tick before clearing.
                        if (r_flash_cnt == FT_W'(FLASH_TOGGLES)) begin
                            r_p1_score <= '0;
                            r_p2_score <= '0;
                            r_winner   <= 2'b00;
                            r_serve_p1 <= 1'b1;
                            r_led      <= '0;
                            r_state    <= ST_IDLE;
                        end else begin
                            r_led       <= ~r_led;
                            r_flash_cnt <= r_flash_cnt + FT_W'(1);
                        end
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign io_bus.led      = r_led;
    assign io_bus.p1_score = r_p1_score;
    assign io_bus.p2_score = r_p2_score;
    assign io_bus.winner   = r_winner;

endmodule

// File: doc/pong_core_param.md
Name: pong_core_param

Overview:
- Parametrised successor of the single-board pong game: a one-dimensional "ball" travels along an N-LED bar between two players, who return it by pressing a button while it sits on their end LED.
- Adds several features over the previous game:
  - configurable bar length, win score and speeds;
  - proper synchroniser/debounce with edge detection;
  - serve alternation;
  - per-return speed-up;
  - a timed win flash.
- Sits between the board buttons and the LED bar / seven-segment score driver; runs entirely on the board clock using tick enables, with no derived clocks.

Parameters:
- N_LEDS, 8, bar length, >=4; p1 end = led[N_LEDS-1], p2 end = led[0]
- WIN_SCORE, 5, points needed to win, 1..2^SCORE_W-1
- SCORE_W, 4, score output width
- TICK_DIV, 10000000, base ball-step period in clk cycles, >=2
- MIN_DIV, 2500000, fastest step period, 2..TICK_DIV
- SPEEDUP_SHIFT, 3, each return shortens the period by period>>SPEEDUP_SHIFT
- DB_CYCLES, 16, consecutive equal samples needed to accept a button level change
- FLASH_TOGGLES, 10, number of LED toggles in the win flash

Ports:
- clk  in  1  board clock; all state on rising edge
- rst  in  1  asynchronous, active-low reset
- p1_btn  in  1  player 1 button, raw, asynchronous
- p2_btn  in  1  player 2 button, raw, asynchronous
- start  in  1  serve/start button, raw, asynchronous
- led  out  N_LEDS  ball position / flash pattern
- p1_score  out  SCORE_W  player 1 points
- p2_score  out  SCORE_W  player 2 points
- winner  out  2  01 = p1 won, 10 = p2 won, 00 = none; valid during FLASH

Behaviour:

Reset (rst=0, asynchronous, any state):
- state = IDLE, led = 0, scores = 0, winner = 00
- serve_p1 = 1, period = TICK_DIV, tick counter = 0, debouncers = 0

Inputs:
- Each input passes through a 2-FF synchroniser, then a debouncer.
- The debounced level changes only after DB_CYCLES consecutive samples differ from it.
- A rising edge of the debounced level produces a one-cycle press pulse.
- Latency from raw edge to pulse is 2 + DB_CYCLES + 1 cycles.
- A held button gives exactly one pulse.

Tick and ball:
- Tick counter counts 0..period-1; a tick pulse fires at period-1, then the counter wraps to 0.
- The counter is cleared on entering SERVE, PLAY or FLASH, and on every return.
- Ball is held as index pos (clog2(N_LEDS) bits) and dir (1 = toward p1, increasing index).
- led = one-hot(pos) in SERVE and PLAY; 0 in IDLE.

State machine:
- IDLE:
  - led = 0.
  - start pulse -> SERVE. Button presses are ignored.
- SERVE (1 cycle):
  - If serve_p1: pos = N_LEDS-2, dir = 0. Otherwise: pos = 1, dir = 1.
  - period = TICK_DIV. -> PLAY.
- PLAY: only the player the ball moves toward is evaluated (p1 when dir=1, p2 when dir=0); the other player's presses are ignored.
  - Receiver press with ball on receiver's end (pos = N_LEDS-1 for p1, 0 for p2):
    - return: dir flips, tick counter cleared;
    - period = max(period - (period>>SPEEDUP_SHIFT), MIN_DIV).
  - Receiver press elsewhere: opponent scores -> POINT.
  - Tick with ball on receiver's end and no return: miss, opponent scores -> POINT.
  - Other tick: pos moves one step in dir.
  - Press and tick in the same cycle: the press wins.
- POINT (1 cycle):
  - Score register already incremented on entry.
  - If that score equals WIN_SCORE: winner set, -> FLASH.
  - Otherwise: serve_p1 toggles, -> IDLE.
  - Scores never exceed WIN_SCORE.
- FLASH:
  - led starts at all-ones and inverts on each TICK_DIV tick.
  - start and buttons are ignored.
  - After FLASH_TOGGLES inversions: scores = 0, winner = 00, serve_p1 = 1, led = 0, -> IDLE.

Test Plan:
(Bench parameters: N_LEDS=8, TICK_DIV=20, MIN_DIV=8, SPEEDUP_SHIFT=2, DB_CYCLES=3, WIN_SCORE=2, FLASH_TOGGLES=4.)
- Reset mid-PLAY with led=0x10:
  - drive rst=0 -> led=0, scores=0, winner=00 immediately, without waiting for clk;
  - release rst, pulse start -> led=0x40, then 0x20 after 20 cycles.
- Button bounce: p1_btn toggles every cycle for 10 cycles, then holds 1 -> exactly one press pulse, 6 cycles after the hold begins.
- p1 serves, no presses -> ball steps 0x40, 0x20 … 0x01 every 20 cycles; a tick on 0x01 gives p1_score=1 -> IDLE; the next serve starts at 0x02 moving up.
- Rally with p1 and p2 returning on their end LEDs -> step period goes 20, 15, 12, 9, 8, 8; scores stay unchanged.
- Early press: p1 presses while led=0x20, ball moving toward p1 -> p2_score+1. A p2 press in the same state is ignored.
- Win: p1 reaches 2 -> winner=01, led=0xFF, 0x00, 0xFF, 0x00, 0xFF at 20-cycle intervals, then scores=0, winner=00, IDLE; start is ignored during the flash.
